snitch_tcdm_amo_adapter: RTL and testbench

Per-bank adapter between one output port of the TCDM router and one single-port SRAM bank. Plain loads and stores pass straight through with a fixed one-cycle response latency, as the router's response path expects. RISC-V atomics (AMOs, LR/SC) are executed in the bank as read-modify-write sequences, with one load reservation per bank.

---
 rtl/snitch_tcdm_amo_adapter.sv | 206 ++++++++++++++++++++
 tb/tb_snitch_tcdm_amo_adapter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_tcdm_amo_adapter.sv
`default_nettype none
// ============================================================================
// Module   : snitch_tcdm_amo_adapter
// Brief    : Per-bank adapter between a TCDM router port and a single-port
//            SRAM bank. Plain loads/stores pass through with one-cycle
//            response latency; AMOs run as a two-cycle read-modify-write;
//            LR/SC use a single per-bank reservation.
// Revision : 1.0 - initial release
// ============================================================================
module snitch_tcdm_amo_adapter #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned IdWidth      = 5,
    parameter int unsigned MemAddrWidth = AddrWidth - $clog2(DataWidth/8)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic                     req_write_i,
    input  logic [3:0]               req_amo_i,
    input  logic [DataWidth-1:0]     req_data_i,
    input  logic [DataWidth/8-1:0]   req_strb_i,
    input  logic [IdWidth-1:0]       req_id_i,
    output logic                     rsp_valid_o,
    output logic [DataWidth-1:0]     rsp_data_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [MemAddrWidth-1:0]  mem_addr_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    output logic [DataWidth/8-1:0]   mem_be_o,
    input  logic [DataWidth-1:0]     mem_rdata_i
);

    localparam int unsigned c_BYTE_OFFSET = $clog2(DataWidth/8);
    localparam int unsigned c_NUM_LANES   = DataWidth/32;
    localparam int unsigned c_STRB_WIDTH  = DataWidth/8;

    localparam logic [3:0] c_AMO_SWAP = 4'd1;
    localparam logic [3:0] c_AMO_ADD  = 4'd2;
    localparam logic [3:0] c_AMO_AND  = 4'd3;
    localparam logic [3:0] c_AMO_OR   = 4'd4;
    localparam logic [3:0] c_AMO_XOR  = 4'd5;
    localparam logic [3:0] c_AMO_MAX  = 4'd6;
    localparam logic [3:0] c_AMO_MAXU = 4'd7;
    localparam logic [3:0] c_AMO_MIN  = 4'd8;
    localparam logic [3:0] c_AMO_MINU = 4'd9;
    localparam logic [3:0] c_AMO_LR   = 4'd10;
    localparam logic [3:0] c_AMO_SC   = 4'd11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AMO_WB = 1'b1
    } state_e;

    state_e                     state_q;
    logic                       rsp_valid_q;
    logic                       rsp_sc_q;
    logic                       sc_fail_q;
    logic [3:0]                 amo_op_q;
    logic [31:0]                amo_operand_q;
    logic [MemAddrWidth-1:0]    amo_addr_q;
    logic                       amo_lane_q;
    logic                       resv_valid_q;
    logic [MemAddrWidth-1:0]    resv_addr_q;
    logic [IdWidth-1:0]         resv_id_q;

    logic [MemAddrWidth-1:0]    w_req_waddr;
    logic                       w_req_lane;
    logic [31:0]                w_req_op32;
    logic [31:0]                w_old32;
    logic [31:0]                w_amo_res;
    logic [c_STRB_WIDTH-1:0]    w_req_lane_be;
    logic [c_STRB_WIDTH-1:0]    w_wb_lane_be;
    logic                       w_accept;
    logic                       w_is_amo;
    logic                       w_is_lr;
    logic                       w_is_sc;
    logic                       w_sc_ok;
    logic                       w_unused_bits;

    assign w_req_waddr = req_addr_i[AddrWidth-1:c_BYTE_OFFSET];
    assign req_ready_o = (state_q == IDLE);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_is_amo    = (req_amo_i >= c_AMO_SWAP) && (req_amo_i <= c_AMO_MINU);
    assign w_is_lr     = (req_amo_i == c_AMO_LR);
    assign w_is_sc     = (req_amo_i == c_AMO_SC);
    assign w_sc_ok     = resv_valid_q && (resv_addr_q == w_req_waddr) && (resv_id_q == req_id_i);

    // Atomics act on one 32-bit lane; with a 64-bit bank the lane is addr[2].
    if (DataWidth == 64) begin : g_lane64
        assign w_req_lane    = req_addr_i[2];
        assign w_req_op32    = w_req_lane ? req_data_i[63:32] : req_data_i[31:0];
        assign w_old32       = amo_lane_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        assign w_req_lane_be = w_req_lane ? 8'hF0 : 8'h0F;
        assign w_wb_lane_be  = amo_lane_q ? 8'hF0 : 8'h0F;
    end else begin : g_lane32
        assign w_req_lane    = 1'b0;
        assign w_req_op32    = req_data_i[31:0];
        assign w_old32       = mem_rdata_i[31:0];
        assign w_req_lane_be = '1;
        assign w_wb_lane_be  = '1;
    end

    // Sub-word address bits only select a lane or byte and are otherwise dropped.
    assign w_unused_bits = ^{req_addr_i[c_BYTE_OFFSET-1:0], amo_lane_q, w_req_lane};

    // Modify step of the read-modify-write: old word lane combined with operand.
    always_comb begin
        w_amo_res = w_old32;
        case (amo_op_q)
            c_AMO_SWAP: w_amo_res = amo_operand_q;
            c_AMO_ADD:  w_amo_res = w_old32 + amo_operand_q;
            c_AMO_AND:  w_amo_res = w_old32 & amo_operand_q;
            c_AMO_OR:   w_amo_res = w_old32 | amo_operand_q;
            c_AMO_XOR:  w_amo_res = w_old32 ^ amo_operand_q;
            c_AMO_MAX:  w_amo_res = ($signed(w_old32) > $signed(amo_operand_q)) ? w_old32 : amo_operand_q;
            c_AMO_MAXU: w_amo_res = (w_old32 > amo_operand_q) ? w_old32 : amo_operand_q;
            c_AMO_MIN:  w_amo_res = ($signed(w_old32) < $signed(amo_operand_q)) ? w_old32 : amo_operand_q;
            c_AMO_MINU: w_amo_res = (w_old32 < amo_operand_q) ? w_old32 : amo_operand_q;
            default:    w_amo_res = w_old32;
        endcase
    end

    // SRAM port: write-back owns the port in AMO_WB, otherwise the incoming request does.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = w_req_waddr;
        mem_wdata_o = req_data_i;
        mem_be_o    = req_strb_i;
        if (state_q == AMO_WB) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = amo_addr_q;
            mem_wdata_o = {c_NUM_LANES{w_amo_res}};
            mem_be_o    = w_wb_lane_be;
        end else if (req_valid_i) begin
            if (w_is_amo || w_is_lr) begin
                mem_req_o = 1'b1;
                mem_be_o  = w_req_lane_be;
            end else if (w_is_sc) begin
                mem_req_o   = w_sc_ok;
                mem_we_o    = 1'b1;
                mem_wdata_o = {c_NUM_LANES{w_req_op32}};
                mem_be_o    = w_req_lane_be;
            end else begin
                mem_req_o = 1'b1;
                mem_we_o  = req_write_i;
            end
        end
    end

    // SC answers from its registered result; everything else reads the SRAM port.
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = !rsp_valid_q ? '0 :
                         rsp_sc_q     ? {{(DataWidth-1){1'b0}}, sc_fail_q} :
                                        mem_rdata_i;

    // FSM, response pipeline, AMO capture and the load reservation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_sc_q      <= 1'b0;
            sc_fail_q     <= 1'b0;
            amo_op_q      <= '0;
            amo_operand_q <= '0;
            amo_addr_q    <= '0;
            amo_lane_q    <= 1'b0;
            resv_valid_q  <= 1'b0;
            resv_addr_q   <= '0;
            resv_id_q     <= '0;
        end else begin
            rsp_valid_q <= w_accept;
            rsp_sc_q    <= w_accept & w_is_sc;
            sc_fail_q   <= ~w_sc_ok;

            case (state_q)
                IDLE: begin
                    if (w_accept && w_is_amo) begin
                        state_q       <= AMO_WB;
                        amo_op_q      <= req_amo_i;
                        amo_operand_q <= w_req_op32;
                        amo_addr_q    <= w_req_waddr;
                        amo_lane_q    <= w_req_lane;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // LR can never coincide with a write, so it simply takes priority.
            if (w_accept && w_is_lr) begin
                resv_valid_q <= 1'b1;
                resv_addr_q  <= w_req_waddr;
                resv_id_q    <= req_id_i;
            end else if ((w_accept && w_is_sc) ||
                         (mem_req_o && mem_we_o && (mem_addr_o == resv_addr_q))) begin
                resv_valid_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snitch_tcdm_amo_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snitch_tcdm_amo_adapter
// Brief    : Self-checking bench: directed scenarios plus a random request
//            stream compared against a transaction-level memory/reservation
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snitch_tcdm_amo_adapter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 5;
    localparam int MAW = 30;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [AW-1:0]  req_addr_i;
    logic           req_write_i;
    logic [3:0]     req_amo_i;
    logic [DW-1:0]  req_data_i;
    logic [3:0]     req_strb_i;
    logic [IW-1:0]  req_id_i;
    logic           rsp_valid_o;
    logic [DW-1:0]  rsp_data_o;
    logic           mem_req_o;
    logic           mem_we_o;
    logic [MAW-1:0] mem_addr_o;
    logic [DW-1:0]  mem_wdata_o;
    logic [3:0]     mem_be_o;
    logic [DW-1:0]  mem_rdata_i;

    always #5 clk = ~clk;

    snitch_tcdm_amo_adapter #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MemAddrWidth(MAW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_amo_i(req_amo_i),
        .req_data_i(req_data_i), .req_strb_i(req_strb_i), .req_id_i(req_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    // Single-port SRAM bank, read-first, one-cycle read latency.
    logic [31:0] sram [16];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o[3:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata_i <= sram[mem_addr_o[3:0]];
        end
    end

    // Reference model state: memory contents and the one reservation.
    logic [31:0] mdl [16];
    bit          m_rv;
    int          m_raddr;
    int          m_rid;

    // Expectations for the next observed cycle.
    bit          exp_rv;
    bit          exp_chk;
    logic [31:0] exp_rd;
    bit          exp_rdy;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Transaction-level semantics of one accepted request.
    task automatic model_req(input logic [3:0] amo, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input int id,
                             output logic [31:0] rd, output bit chk, output bit is_amo,
                             output bit sc_fail);
        int idx;
        logic [31:0] old;
        idx = int'(addr[5:2]);
        old = mdl[idx];
        chk = 1'b1;
        is_amo = (amo >= 1 && amo <= 9);
        sc_fail = 1'b0;
        rd = old;
        if (is_amo) begin
            case (amo)
                4'd1: mdl[idx] = data;
                4'd2: mdl[idx] = old + data;
                4'd3: mdl[idx] = old & data;
                4'd4: mdl[idx] = old | data;
                4'd5: mdl[idx] = old ^ data;
                4'd6: mdl[idx] = ($signed(old) > $signed(data)) ? old : data;
                4'd7: mdl[idx] = (old > data) ? old : data;
                4'd8: mdl[idx] = ($signed(old) < $signed(data)) ? old : data;
                default: mdl[idx] = (old < data) ? old : data;
            endcase
            if (m_rv && m_raddr == idx) m_rv = 1'b0;
        end else if (amo == 4'd10) begin
            m_rv = 1'b1; m_raddr = idx; m_rid = id;
        end else if (amo == 4'd11) begin
            if (m_rv && m_raddr == idx && m_rid == id) begin
                mdl[idx] = data;
                rd = 32'd0;
            end else begin
                sc_fail = 1'b1;
                rd = 32'd1;
            end
            m_rv = 1'b0;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            if (m_rv && m_raddr == idx) m_rv = 1'b0;
            chk = 1'b0;
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit v, input logic [3:0] amo, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int id, output bit acc);
        logic [31:0] rd;
        bit chk, is_amo, sc_fail;
        check_eq("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
        if (exp_rv && exp_chk) check_eq("rsp_data", 64'(rsp_data_o), 64'(exp_rd));
        check_eq("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        req_valid_i = v; req_amo_i = amo; req_write_i = wr; req_addr_i = addr;
        req_data_i = data; req_strb_i = strb; req_id_i = IW'(id);
        acc = v && exp_rdy;
        exp_rv = acc;
        exp_rdy = 1'b1;
        if (acc) begin
            model_req(amo, wr, addr, data, strb, id, rd, chk, is_amo, sc_fail);
            exp_rd = rd; exp_chk = chk;
            if (is_amo) exp_rdy = 1'b0;
            #1;
            if (sc_fail) begin
                check_eq("sc_fail_noreq", 64'(mem_req_o), 64'd0);
            end else begin
                check_eq("acc_mem_req", 64'(mem_req_o), 64'd1);
                check_eq("acc_mem_addr", 64'(mem_addr_o), 64'(addr[31:2]));
                check_eq("acc_mem_we", 64'(mem_we_o), 64'((amo == 0 || amo > 11) && wr || amo == 11));
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] amo, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input int id);
        bit acc;
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 4) begin
            step(1'b1, amo, wr, addr, data, strb, id, acc);
            tries++;
        end
        if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 0, acc);
    endtask

    bit          acc_a, acc_b;
    logic [31:0] saved;
    logic [3:0]  r_amo;

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_amo_i = '0; req_write_i = 1'b0; req_addr_i = '0;
        req_data_i = '0; req_strb_i = '0; req_id_i = '0;
        m_rv = 1'b0; m_raddr = 0; m_rid = 0;
        exp_rv = 1'b0; exp_chk = 1'b0; exp_rd = '0; exp_rdy = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("reset_rsp_data", 64'(rsp_data_o), 64'd0);
        check_eq("reset_ready", 64'(req_ready_o), 64'd1);
        check_eq("reset_mem_req", 64'(mem_req_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Preload every word through the adapter.
        for (int i = 0; i < 16; i++) issue(4'd0, 1'b1, 32'(i*4), $urandom, 4'hF, 0);

        // Store then load back-to-back.
        step(1'b1, 4'd0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, acc_a);
        step(1'b1, 4'd0, 1'b0, 32'h10, 32'h0, 4'h0, 1, acc_b);
        check_eq("b2b_accepts", 64'({acc_a, acc_b}), 64'b11);
        idle(1);

        // AmoAdd wrap, with a load held off during write-back.
        issue(4'd0, 1'b1, 32'h14, 32'd5, 4'hF, 0);
        issue(4'd2, 1'b0, 32'h14, 32'hFFFFFFFF, 4'h0, 0);
        issue(4'd0, 1'b0, 32'h14, 32'h0, 4'h0, 0);
        idle(1);

        // Signed vs unsigned max.
        issue(4'd0, 1'b1, 32'h18, 32'h80000000, 4'hF, 0);
        issue(4'd6, 1'b0, 32'h18, 32'd1, 4'h0, 0);
        issue(4'd0, 1'b0, 32'h18, 32'h0, 4'h0, 0);
        issue(4'd0, 1'b1, 32'h18, 32'h80000000, 4'hF, 0);
        issue(4'd7, 1'b0, 32'h18, 32'd1, 4'h0, 0);
        issue(4'd0, 1'b0, 32'h18, 32'h0, 4'h0, 0);
        idle(1);

        // LR/SC success then repeated SC failure.
        issue(4'd10, 1'b0, 32'h20, 32'h0, 4'h0, 3);
        issue(4'd11, 1'b0, 32'h20, 32'd7, 4'h0, 3);
        issue(4'd11, 1'b0, 32'h20, 32'd9, 4'h0, 3);
        issue(4'd0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
        idle(1);

        // Foreign store breaks the reservation.
        issue(4'd10, 1'b0, 32'h20, 32'h0, 4'h0, 3);
        issue(4'd0, 1'b1, 32'h20, 32'h12345678, 4'hF, 1);
        issue(4'd11, 1'b0, 32'h20, 32'hAAAA5555, 4'h0, 3);
        issue(4'd0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
        idle(1);

        // Reset during write-back drops the write and the response.
        saved = mdl[12];
        issue(4'd2, 1'b0, 32'h30, 32'd1, 4'h0, 0);
        req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_wb_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_wb_ready", 64'(req_ready_o), 64'd1);
        mdl[12] = saved;
        m_rv = 1'b0;
        exp_rv = 1'b0; exp_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(4'd0, 1'b0, 32'h30, 32'h0, 4'h0, 0);
        idle(1);

        // Random mix of loads, stores, AMOs and LR/SC on a few hot words.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0:       r_amo = 4'd0;
                1:       r_amo = 4'($urandom_range(1, 9));
                2:       r_amo = 4'd10;
                3:       r_amo = 4'd11;
                4:       r_amo = 4'($urandom_range(0, 15));
                default: r_amo = 4'($urandom_range(1, 9));
            endcase
            issue(r_amo, 1'($urandom), 32'($urandom_range(0, 15)), $urandom,
                  4'($urandom), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        for (int i = 0; i < 16; i++) check_eq("final_sram", 64'(sram[i]), 64'(mdl[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
